// File: rtl/ctr_pkg.sv
// Shared definitions for the down-counter family: mode encodings and mode decode.
// Latency: none (package only).
// Backpressure: not applicable.
package ctr_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_RELOAD = 2'b10
    } mode_e;

    // The unused encoding 2'b11 folds onto WRAP so the datapath never sees an illegal mode.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_SAT;
            2'b10:   return MODE_RELOAD;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/down_counter_nbit_if.sv
// Control/status bundle between a counter user and down_counter_nbit.
// Latency: none (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface down_counter_nbit_if #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
);
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic [STEP_W-1:0] step;
    logic [1:0]        mode;
    logic              clr_flags;
    logic [WIDTH-1:0]  count;
    logic              zero;
    logic              tc;
    logic              underflow;
    logic              ovf;
    logic              uf_sticky;

    modport master (
        output load, load_val, en, step, mode, clr_flags,
        input  count, zero, tc, underflow, ovf, uf_sticky
    );

    modport slave (
        input  load, load_val, en, step, mode, clr_flags,
        output count, zero, tc, underflow, ovf, uf_sticky
    );
endinterface

// File: rtl/subtractor_nbit.sv
// Unsigned/signed subtractor A - B reporting borrow and two's-complement overflow.
// Latency: combinational.
// Backpressure: not applicable.
module subtractor_nbit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    logic [WIDTH:0] full;

    // One extra bit catches the unsigned borrow out of the MSB.
    always_comb begin
        full     = {1'b0, A} - {1'b0, B};
        diff     = full[WIDTH-1:0];
        borrow   = full[WIDTH];
        // Operands of differing sign whose result sign differs from A cannot be represented.
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (full[WIDTH-1] != A[WIDTH-1]);
    end

endmodule

// File: rtl/down_counter_nbit.sv
// Registered N-bit down-counter with variable step and wrap/saturate/reload underflow modes.
// Latency: 1 cycle from sampling edge to count and flags.
// Backpressure: none; load/en are accepted every cycle (rst > load > en).
module down_counter_nbit
    import ctr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    down_counter_nbit_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_nxt;
    logic [WIDTH-1:0] rel_q, rel_nxt;
    logic             zero_q;
    logic             tc_q, tc_nxt;
    logic             uf_q, uf_nxt;
    logic             ovf_q, ovf_nxt;
    logic             stk_q, stk_nxt;

    logic [WIDTH-1:0] step_ext;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;
    logic             sub_ovf;
    mode_e            mode_d;

    assign step_ext = WIDTH'(bus.step);
    assign mode_d   = decode_mode(bus.mode);

    subtractor_nbit #(.WIDTH(WIDTH)) u_sub (
        .A        (cnt_q),
        .B        (step_ext),
        .diff     (sub_diff),
        .borrow   (sub_borrow),
        .overflow (sub_ovf)
    );

    // Next count, reload value and pulse flags; load beats en, step of 0 is a hold.
    always_comb begin
        cnt_nxt = cnt_q;
        rel_nxt = rel_q;
        tc_nxt  = 1'b0;
        uf_nxt  = 1'b0;
        ovf_nxt = 1'b0;
        if (bus.load) begin
            cnt_nxt = bus.load_val;
            rel_nxt = bus.load_val;
        end else if (bus.en && (bus.step != '0)) begin
            ovf_nxt = sub_ovf;
            if (!sub_borrow) begin
                cnt_nxt = sub_diff;
                tc_nxt  = (sub_diff == '0);
            end else begin
                uf_nxt = 1'b1;
                case (mode_d)
                    MODE_SAT: begin
                        cnt_nxt = '0;
                        // Already parked at zero: do not signal terminal count again.
                        tc_nxt  = (cnt_q != '0);
                    end
                    MODE_RELOAD: cnt_nxt = rel_q;
                    default:     cnt_nxt = sub_diff;
                endcase
            end
        end
        // A fresh underflow outranks a simultaneous clear.
        stk_nxt = uf_nxt | (stk_q & ~bus.clr_flags);
    end

    // State and flag registers with asynchronous reset to RESET_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RESET_VAL;
            rel_q  <= RESET_VAL;
            zero_q <= (RESET_VAL == '0);
            tc_q   <= 1'b0;
            uf_q   <= 1'b0;
            ovf_q  <= 1'b0;
            stk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            rel_q  <= rel_nxt;
            zero_q <= (cnt_nxt == '0);
            tc_q   <= tc_nxt;
            uf_q   <= uf_nxt;
            ovf_q  <= ovf_nxt;
            stk_q  <= stk_nxt;
        end
    end

    assign bus.count     = cnt_q;
    assign bus.zero      = zero_q;
    assign bus.tc        = tc_q;
    assign bus.underflow = uf_q;
    assign bus.ovf       = ovf_q;
    assign bus.uf_sticky = stk_q;

endmodule
